// File: rtl/l2_bank_arbiter.sv
// l2_bank_arbiter: two-requester L2 bank arbiter with anti-starvation priority
// and an owner FIFO that routes in-order memory responses back to the
// requester that issued them. Request and response paths are combinational.
// Optional conflict counter enabled by defining L2_BANK_ARBITER_PERF_EN.
module l2_bank_arbiter #(
    parameter int unsigned MAX_WAIT    = 4,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_add_i,
    input  logic        m0_wen_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_r_valid_o,
    output logic [31:0] m0_r_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_add_i,
    input  logic        m1_wen_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_r_valid_o,
    output logic [31:0] m1_r_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_add_o,
    output logic        mem_wen_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
`ifdef L2_BANK_ARBITER_PERF_EN
    input  logic        perf_clr_i,
    output logic [15:0] perf_conflict_o,
`endif
    input  logic        mem_gnt_i,
    input  logic        mem_r_valid_i,
    input  logic [31:0] mem_r_rdata_i
);

    localparam int unsigned PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(OUTSTANDING + 1);
    localparam int unsigned WAIT_W = 4;

    logic [OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [WAIT_W-1:0]      wait_q;
    logic [31:0]            rdata0_q;
    logic [31:0]            rdata1_q;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic sel1;
    logic head;

    // Wrap-around pointer increment for a FIFO of OUTSTANDING entries
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Arbitration, request pass-through and response routing
    always_comb begin
        full         = (count_q == CNT_W'(OUTSTANDING));
        empty        = (count_q == '0);
        pop          = mem_r_valid_i & ~empty;
        head         = owner_q[rd_ptr_q];
        // Port 1 wins when alone, or when it has waited MAX_WAIT cycles
        sel1         = m1_req_i & (~m0_req_i | (wait_q == WAIT_W'(MAX_WAIT)));
        // A full FIFO only blocks if no entry retires this same cycle
        mem_req_o    = rst_ni & (m0_req_i | m1_req_i) & (~full | mem_r_valid_i);
        push         = mem_req_o & mem_gnt_i;
        m0_gnt_o     = push & ~sel1;
        m1_gnt_o     = push & sel1;
        mem_add_o    = sel1 ? m1_add_i   : m0_add_i;
        mem_wen_o    = sel1 ? m1_wen_i   : m0_wen_i;
        mem_be_o     = sel1 ? m1_be_i    : m0_be_i;
        mem_wdata_o  = sel1 ? m1_wdata_i : m0_wdata_i;
        m0_r_valid_o = pop & ~head;
        m1_r_valid_o = pop & head;
        m0_r_rdata_o = m0_r_valid_o ? mem_r_rdata_i : rdata0_q;
        m1_r_rdata_o = m1_r_valid_o ? mem_r_rdata_i : rdata1_q;
    end

    // Owner FIFO: records which port owns each outstanding transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel1;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Saturating count of consecutive cycles port 1 was left waiting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else if (!m1_req_i || m1_gnt_o) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // Hold the last routed response data per port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (m0_r_valid_o) rdata0_q <= mem_r_rdata_i;
            if (m1_r_valid_o) rdata1_q <= mem_r_rdata_i;
        end
    end

`ifdef L2_BANK_ARBITER_PERF_EN
    // Saturating count of cycles where both ports request; clear dominates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_conflict_o <= '0;
        end else if (perf_clr_i) begin
            perf_conflict_o <= '0;
        end else if (m0_req_i && m1_req_i && (perf_conflict_o != 16'hFFFF)) begin
            perf_conflict_o <= perf_conflict_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed, table-driven bench for l2_bank_arbiter (default parameters).
module tb_l2_bank_arbiter;

    localparam logic [31:0] M0_ADD   = 32'h1C01_0000;
    localparam logic [31:0] M1_ADD   = 32'h2000_0000;
    localparam logic [31:0] M0_WDATA = 32'h0BAD_0000;
    localparam logic [31:0] M1_WDATA = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_wen, m0_gnt, m0_rv;
    logic [31:0] m0_add, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_wen, m1_gnt, m1_rv;
    logic [31:0] m1_add, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_req, mem_wen, mem_gnt, mem_rv;
    logic [31:0] mem_add, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef L2_BANK_ARBITER_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_conflict;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2_bank_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_i(m0_req), .m0_add_i(m0_add), .m0_wen_i(m0_wen), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_r_valid_o(m0_rv), .m0_r_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_add_i(m1_add), .m1_wen_i(m1_wen), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_r_valid_o(m1_rv), .m1_r_rdata_o(m1_rdata),
        .mem_req_o(mem_req), .mem_add_o(mem_add), .mem_wen_o(mem_wen), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata),
`ifdef L2_BANK_ARBITER_PERF_EN
        .perf_clr_i(perf_clr), .perf_conflict_o(perf_conflict),
`endif
        .mem_gnt_i(mem_gnt), .mem_r_valid_i(mem_rv), .mem_r_rdata_i(mem_rdata)
    );

    typedef struct {
        logic        m0_req, m1_req, gnt, rv;
        logic [31:0] rdata;
        logic        e_req, e_g0, e_g1, e_rv0, e_rv1, e_sel1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    function automatic vec_t mk(input logic a, b, g, v, input logic [31:0] d,
                                input logic er, eg0, eg1, ev0, ev1, es1,
                                input logic [31:0] ed0, ed1);
        vec_t t;
        t.m0_req = a;  t.m1_req = b;  t.gnt = g;  t.rv = v;  t.rdata = d;
        t.e_req = er;  t.e_g0 = eg0;  t.e_g1 = eg1;
        t.e_rv0 = ev0; t.e_rv1 = ev1; t.e_sel1 = es1;
        t.e_rd0 = ed0; t.e_rd1 = ed1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];
    logic pat[10];

    initial begin
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        vecs[0]  = mk(0,0,1,1,32'hDEAD_0000, 0,0,0,0,0,0, 32'h0,         32'h0);
        vecs[1]  = mk(1,0,1,0,32'h0,         1,1,0,0,0,0, 32'h0,         32'h0);
        vecs[2]  = mk(0,0,1,1,32'hA5A5_0001, 0,0,0,1,0,0, 32'hA5A5_0001, 32'h0);
        vecs[3]  = mk(0,1,1,0,32'h0,         1,0,1,0,0,1, 32'hA5A5_0001, 32'h0);
        vecs[4]  = mk(0,0,1,1,32'h1111_2222, 0,0,0,0,1,0, 32'hA5A5_0001, 32'h1111_2222);
        vecs[5]  = mk(1,0,1,0,32'h0,         1,1,0,0,0,0, 32'hA5A5_0001, 32'h1111_2222);
        vecs[6]  = mk(1,0,1,0,32'h0,         1,1,0,0,0,0, 32'hA5A5_0001, 32'h1111_2222);
        vecs[7]  = mk(1,0,1,0,32'h0,         0,0,0,0,0,0, 32'hA5A5_0001, 32'h1111_2222);
        vecs[8]  = mk(1,0,1,1,32'h33,        1,1,0,1,0,0, 32'h33,        32'h1111_2222);
        vecs[9]  = mk(0,0,1,1,32'h44,        0,0,0,1,0,0, 32'h44,        32'h1111_2222);
        vecs[10] = mk(0,1,0,0,32'h0,         1,0,0,0,0,1, 32'h44,        32'h1111_2222);
        vecs[11] = mk(0,0,1,1,32'h55,        0,0,0,1,0,0, 32'h55,        32'h1111_2222);
        vecs[12] = mk(0,0,1,1,32'h66,        0,0,0,0,0,0, 32'h55,        32'h1111_2222);
        vecs[13] = mk(1,1,1,0,32'h0,         1,1,0,0,0,0, 32'h55,        32'h1111_2222);
        vecs[14] = mk(0,0,1,1,32'h77,        0,0,0,1,0,0, 32'h77,        32'h1111_2222);

        rst_ni = 1'b0;
        m0_req = 0; m0_add = M0_ADD; m0_wen = 1'b1; m0_be = 4'hF; m0_wdata = M0_WDATA;
        m1_req = 0; m1_add = M1_ADD; m1_wen = 1'b0; m1_be = 4'h3; m1_wdata = M1_WDATA;
        mem_gnt = 0; mem_rv = 0; mem_rdata = '0;
`ifdef L2_BANK_ARBITER_PERF_EN
        perf_clr = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'h0);
        chk("reset_rv", 32'({m0_rv, m1_rv}), 32'h0);
        chk("reset_rdata0", m0_rdata, 32'h0);
        rst_ni = 1'b1;
        step();

        // Table-driven single-cycle vectors
        for (int i = 0; i < 15; i++) begin
            m0_req = vecs[i].m0_req; m1_req = vecs[i].m1_req;
            mem_gnt = vecs[i].gnt;   mem_rv = vecs[i].rv;   mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_gnt0", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
            chk($sformatf("v%0d_gnt1", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
            chk($sformatf("v%0d_rv0", i), 32'(m0_rv), 32'(vecs[i].e_rv0));
            chk($sformatf("v%0d_rv1", i), 32'(m1_rv), 32'(vecs[i].e_rv1));
            chk($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].e_rd0);
            chk($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].e_rd1);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_add", i), mem_add, vecs[i].e_sel1 ? M1_ADD : M0_ADD);
                chk($sformatf("v%0d_wen", i), 32'(mem_wen), vecs[i].e_sel1 ? 32'h0 : 32'h1);
                chk($sformatf("v%0d_be", i), 32'(mem_be), vecs[i].e_sel1 ? 32'h3 : 32'hF);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_sel1 ? M1_WDATA : M0_WDATA);
            end
            step();
        end

        // Starvation: both ports request, 1-cycle memory response
        for (int k = 0; k <= 10; k++) begin
            m0_req = (k < 10); m1_req = (k < 10); mem_gnt = 1'b1;
            mem_rv = (k > 0);  mem_rdata = 32'h100 + 32'(k);
            #1;
            if (k < 10) begin
                chk($sformatf("starve%0d_gnt0", k), 32'(m0_gnt), 32'(!pat[k]));
                chk($sformatf("starve%0d_gnt1", k), 32'(m1_gnt), 32'(pat[k]));
            end
            if (k > 0) begin
                chk($sformatf("starve%0d_rv0", k), 32'(m0_rv), 32'(!pat[k-1]));
                chk($sformatf("starve%0d_rv1", k), 32'(m1_rv), 32'(pat[k-1]));
                chk($sformatf("starve%0d_rdata", k), pat[k-1] ? m1_rdata : m0_rdata,
                    32'h100 + 32'(k));
            end
            step();
        end

        // Reset with two responses outstanding
        mem_rv = 0; m0_req = 1; m1_req = 0; mem_gnt = 1;
        #1 chk("rst_pre_gnt0", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 0; m1_req = 1;
        #1 chk("rst_pre_gnt1", 32'(m1_gnt), 32'h1);
        step();
        m1_req = 0; m0_req = 1; mem_rv = 1; mem_rdata = 32'hBEEF_0001;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mid_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("rst_mid_rv", 32'({m0_rv, m1_rv}), 32'h0);
        chk("rst_mid_rdata0", m0_rdata, 32'h0);
        chk("rst_mid_rdata1", m1_rdata, 32'h0);
        step();
        m0_req = 0;
        rst_ni = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("rst_post%0d_rv", k), 32'({m0_rv, m1_rv}), 32'h0);
            step();
        end
        mem_rv = 0; m0_req = 1;
        #1 chk("rst_after_gnt0", 32'(m0_gnt), 32'h1);
        step();
        m0_req = 0; mem_rv = 1; mem_rdata = 32'hBEEF_0002;
        #1;
        chk("rst_after_rv0", 32'(m0_rv), 32'h1);
        chk("rst_after_rdata0", m0_rdata, 32'hBEEF_0002);
        step();
        mem_rv = 0;

`ifdef L2_BANK_ARBITER_PERF_EN
        // Conflict counter: clear, count 10 conflicts, clear during a conflict
        mem_gnt = 0; perf_clr = 1;
        step();
        perf_clr = 0;
        chk("perf_clr", 32'(perf_conflict), 32'h0);
        m0_req = 1; m1_req = 1;
        repeat (10) step();
        m0_req = 0; m1_req = 0;
        chk("perf_ten", 32'(perf_conflict), 32'd10);
        m0_req = 1; m1_req = 1; perf_clr = 1;
        step();
        m0_req = 0; m1_req = 0; perf_clr = 0;
        chk("perf_clr_wins", 32'(perf_conflict), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_bank_arbiter.md
L2_BANK_ARBITER -- requirements
Module: l2_bank_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive denied cycles after which port 1 takes priority (range 1..15).
REQ-002 SHALL have parameter OUTSTANDING, default 2, meaning the depth of the response-owner FIFO (power of two, >= 1).
REQ-003 SHALL have one clock, clk_i, input, 1 bit, rising-edge.
REQ-004 SHALL have reset rst_ni, input, 1 bit, asynchronous, active-low.
REQ-005 SHALL have, for each requester n in {0,1}, these inputs:
- mN_req_i (1 bit)
- mN_add_i (32 bits)
- mN_wen_i (1 bit; 1 = read, 0 = write)
- mN_be_i (4 bits)
- mN_wdata_i (32 bits)
REQ-006 SHALL have, for each requester n in {0,1}, these outputs:
- mN_gnt_o (1 bit)
- mN_r_valid_o (1 bit)
- mN_r_rdata_o (32 bits)
REQ-007 SHALL have these memory-side outputs: mem_req_o (1), mem_add_o (32), mem_wen_o (1), mem_be_o (4), mem_wdata_o (32).
REQ-008 SHALL have these memory-side inputs: mem_gnt_i (1), mem_r_valid_i (1), mem_r_rdata_i (32).

Function
REQ-009 SHALL present a request combinationally: mem_req_o = m0_req_i | m1_req_i, provided the owner FIFO is not full; the selected port's add, wen, be and wdata SHALL be passed through unmodified.
REQ-010 SHALL, by default, give port 0 (core) fixed priority when both ports request.
REQ-011 SHALL keep a 4-bit wait counter with these rules:
- increment when m1_req_i=1 and m1 is not granted;
- clear when m1 is granted or m1_req_i=0;
- saturate at MAX_WAIT.
REQ-012 SHALL give port 1 priority while the wait counter equals MAX_WAIT, for that cycle only.
REQ-013 SHALL assert mN_gnt_o only in the same cycle as mem_req_o & mem_gnt_i for the selected port, and never for both ports in one cycle.
REQ-014 SHALL push the granted port index into the owner FIFO on every accepted transfer (mem_req_o & mem_gnt_i), reads and writes alike.
REQ-015 SHALL pop the owner FIFO on mem_r_valid_i and route the response to the head port:
- assert that port's r_valid_o for exactly that cycle;
- drive that port's r_rdata_o with mem_r_rdata_i;
- hold the other port's r_valid_o at 0.
REQ-016 SHALL, when the owner FIFO is full, force mem_req_o=0 and both grants to 0, unless mem_r_valid_i=1 in that cycle; a simultaneous pop and push SHALL be allowed and leave the count unchanged.
REQ-017 SHALL ignore mem_r_valid_i when the owner FIFO is empty: no r_valid_o asserted, FIFO state unchanged.
REQ-018 SHALL add zero cycles of latency on both the request path and the response path.
REQ-019 SHALL hold mN_r_rdata_o at the last routed value between responses.

Reset
REQ-020 SHALL, while rst_ni=0 (asynchronously):
- empty the owner FIFO and set its pointers to 0;
- set the wait counter to 0;
- drive all r_valid_o outputs to 0;
- set all r_rdata_o registers to 0.
REQ-021 SHALL drop outstanding responses on reset asserted mid-transaction; the first mem_r_valid_i after reset is ignored per REQ-017.
REQ-022 SHALL drive grant outputs and mem_req_o purely from the inputs and the FIFO state, so both are 0 during reset.

Configuration
REQ-023 SHALL, when macro L2_BANK_ARBITER_PERF_EN is defined, add two ports:
- perf_clr_i, input, 1 bit;
- perf_conflict_o, output, 16 bits.
perf_conflict_o is a saturating count of cycles with m0_req_i & m1_req_i, reset to 0 and cleared synchronously by perf_clr_i (clear wins over increment).
REQ-024 SHALL, when L2_BANK_ARBITER_PERF_EN is undefined, omit those ports and that counter, with identical arbitration behaviour.

Verification
REQ-025 SHALL cover port-0-only traffic: m0 reads 0x1C010000 with mem_gnt_i=1 and a 1-cycle memory -> m0_gnt_o is high in the same cycle, m0_r_valid_o one cycle later carries the memory data, and m1 outputs stay 0.
REQ-026 SHALL cover starvation: both ports request continuously with MAX_WAIT=4 and mem_gnt_i=1 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1, and responses routed in the same order.
REQ-027 SHALL cover back-pressure: OUTSTANDING=2, mem_gnt_i=1, mem_r_valid_i held 0 -> two grants, then mem_req_o=0; asserting mem_r_valid_i for one cycle re-enables the grant in that same cycle.
REQ-028 SHALL cover stray responses: mem_r_valid_i=1 with the FIFO empty -> both r_valid_o stay 0 and the next transfer routes correctly.
REQ-029 SHALL cover reset mid-operation: rst_ni falls with 2 responses outstanding -> the FIFO empties immediately and no r_valid_o appears after release.
REQ-030 SHALL cover the performance counter (L2_BANK_ARBITER_PERF_EN defined): 10 conflict cycles -> perf_conflict_o=10; perf_clr_i asserted in a conflict cycle -> 0.
